fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined MIPS core.
- Generalises operand forwarding to NUM_SRC source operands and NUM_FWD_STAGES producer stages, with strict nearest-stage priority.
- Adds a load-use stall state machine with a configurable load latency.
- Sits beside the ID/EX register: drives the EX-stage operand mux selects, PC/IF_ID hold (Stall) and ID/EX flush (Bubble).

Parameters:
- REG_AW, 5: register address width.
- NUM_SRC, 2: number of source operands per instruction (Rs, Rt, ...).
- NUM_FWD_STAGES, 2: number of producer stages. Stage 0 is nearest (EX/Mem), stage 1 is Mem/WB, and so on.
- LOAD_LAT, 1: stall cycles inserted per load-use hazard, range 1..15.
- SEL_W, $clog2(NUM_FWD_STAGES+1): width of each mux select.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous reset, active-high.
- ID_EX_Src  in  NUM_SRC*REG_AW  source register numbers of the instruction in EX; operand i is at [i*REG_AW +: REG_AW].
- ID_EX_SrcUse  in  NUM_SRC  operand i is actually read.
- Prod_RegWrite  in  NUM_FWD_STAGES  stage k writes a register.
- Prod_RegRd  in  NUM_FWD_STAGES*REG_AW  destination register of stage k.
- IF_ID_Src  in  NUM_SRC*REG_AW  source registers of the instruction in ID.
- IF_ID_SrcUse  in  NUM_SRC  operand i of the ID instruction is read.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegRd  in  REG_AW  destination of the instruction in EX.
- Fwd_Sel  out  NUM_SRC*SEL_W  registered mux selects.
- Stall  out  1  hold PC and IF_ID.
- Bubble  out  1  zero the ID/EX control fields.
- Stall_Count  out  32  stall cycles (optional feature).
- Fwd_Count  out  32  forwarding events (optional feature).

Behaviour:
- Reset (Rst=1 at a posedge) forces:
  - Fwd_Sel = 0.
  - FSM = IDLE, stall counter = 0.
  - Stall_Count = 0, Fwd_Count = 0.
  - Consequently Stall = Bubble = 0 from the following cycle.
  - Reset mid-stall aborts the stall immediately.
- Forward select encoding: 0 = register-file/pipe value; k+1 = stage k result.
- Fwd_Sel is registered: computed from the inputs at posedge N and valid after posedge N, for use in the EX cycle that follows (same timing as the existing forwarding muxes).
- Select rule for operand i: pick the lowest k satisfying all of:
  - ID_EX_SrcUse[i]=1
  - Prod_RegWrite[k]=1
  - Prod_RegRd[k] != 0
  - Prod_RegRd[k] == src_i
- Select = k+1 for that k; if no stage matches, select = 0.
- Consequences of the select rule:
  - A nearer stage always shadows a farther stage with the same Rd.
  - Register 0 is never forwarded.
- Hazard detect (combinational): ID_EX_MemRead=1 and ID_EX_RegRd != 0 and, for some i, IF_ID_SrcUse[i]=1 and IF_ID_Src_i == ID_EX_RegRd.
- FSM states and transitions:
  - IDLE: on hazard, Stall=Bubble=1 in the same cycle. If LOAD_LAT>1, load the counter with LOAD_LAT-1 and go to STALL; otherwise stay in IDLE.
  - STALL: Stall=Bubble=1. Counter decrements each cycle; return to IDLE when it reaches 1 and decrements to 0.
  - STALL: new hazard detects are ignored. The pipeline is frozen, so the hazard is re-evaluated in IDLE.
- Total stall cycles per hazard = LOAD_LAT exactly.
- Simultaneous hazard and forwarding: Fwd_Sel still updates every cycle; the forwarding path does not depend on Stall.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined:
  - Stall_Count increments by 1 each cycle Stall=1.
  - Fwd_Count increments by the number of operands whose next Fwd_Sel != 0.
  - Both counters wrap at 2^32; both clear on Rst.
- When undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset: Rst=1 for 2 cycles with arbitrary inputs -> Fwd_Sel=0, Stall=0, Bubble=0, counters=0.
- Nearest-stage priority: src0=5; stage0 Rd=5, RegWrite=1; stage1 Rd=5, RegWrite=1 -> next cycle Fwd_Sel[0]=1. Then drop stage0 RegWrite -> Fwd_Sel[0]=2.
- Register zero: src1=0, stage0 Rd=0, RegWrite=1 -> Fwd_Sel[1]=0. With SrcUse[1]=0 and src1=7, stage0 Rd=7 -> Fwd_Sel[1]=0.
- Load-use, LOAD_LAT=1: MemRead=1, ID_EX_RegRd=8, IF_ID src0=8, IF_ID_SrcUse[0]=1 -> Stall=Bubble=1 for exactly 1 cycle.
- Load-use, LOAD_LAT=3: same stimulus held -> Stall high for 3 consecutive cycles. Assert Rst in the 2nd stall cycle -> Stall=0 the next cycle.
- Perf counters (with FWD_HAZARD_PERF_EN): 2 operands forwarded for 4 cycles plus one LOAD_LAT=2 stall -> Fwd_Count=8, Stall_Count=2. Without the macro -> both outputs 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall/bubble control for the pipelined MIPS core.
// Optional performance counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic [NUM_SRC*REG_AW-1:0]        ID_EX_Src,
    input  logic [NUM_SRC-1:0]               ID_EX_SrcUse,
    input  logic [NUM_FWD_STAGES-1:0]        Prod_RegWrite,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] Prod_RegRd,
    input  logic [NUM_SRC*REG_AW-1:0]        IF_ID_Src,
    input  logic [NUM_SRC-1:0]               IF_ID_SrcUse,
    input  logic                             ID_EX_MemRead,
    input  logic [REG_AW-1:0]                ID_EX_RegRd,
    output logic [NUM_SRC*SEL_W-1:0]         Fwd_Sel,
    output logic                             Stall,
    output logic                             Bubble,
    output logic [31:0]                      Stall_Count,
    output logic [31:0]                      Fwd_Count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q, fwd_sel_d;
    logic                       hazard;
    logic                       stall;

    // Walk stages farthest-first so the nearest matching stage overwrites last and wins.
    always_comb begin
        fwd_sel_d = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int k = int'(NUM_FWD_STAGES) - 1; k >= 0; k--) begin
                if (ID_EX_SrcUse[i] && Prod_RegWrite[k] &&
                    (Prod_RegRd[k*REG_AW +: REG_AW] != '0) &&
                    (Prod_RegRd[k*REG_AW +: REG_AW] == ID_EX_Src[i*REG_AW +: REG_AW])) begin
                    fwd_sel_d[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (ID_EX_MemRead && (ID_EX_RegRd != '0)) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (IF_ID_SrcUse[i] && (IF_ID_Src[i*REG_AW +: REG_AW] == ID_EX_RegRd)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = StStall;
                        cnt_d   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            StStall: begin
                // Pipeline is frozen here; any hazard is re-evaluated once back in idle.
                stall = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (Rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fwd_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign Fwd_Sel = fwd_sel_q;
    assign Stall   = stall;
    assign Bubble  = stall;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_inc;

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (fwd_sel_d[i*SEL_W +: SEL_W] != '0) begin
                fwd_inc = fwd_inc + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall};
            fwd_cnt_q   <= fwd_cnt_q + fwd_inc;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Fwd_Count   = fwd_cnt_q;
`else
    assign Stall_Count = '0;
    assign Fwd_Count   = '0;
`endif

endmodule
